// File: rtl/ex_stage.sv
// RV32I execute stage: ID/EX register, operand forwarding,
// ALU, branch condition and redirect target generation.
module ex_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic [1:0]      ResultSrcD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            JalrD,
  input  logic            ALUSrcD,
  input  logic [3:0]      ALUControlD,
  input  logic [2:0]      funct3D,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCplus4D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic [4:0]      rdD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultM,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic [1:0]      ResultSrcE,
  output logic [4:0]      rdE,
  output logic [4:0]      rs1E,
  output logic [4:0]      rs2E,
  output logic [XLEN-1:0] PCplus4E,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            PCSrcE
);

  logic            r_reg_write;
  logic            r_mem_write;
  logic [1:0]      r_result_src;
  logic            r_branch;
  logic            r_jump;
  logic            r_jalr;
  logic            r_alu_src;
  logic [3:0]      r_alu_ctrl;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc4;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;

  logic [XLEN-1:0] w_srca;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_srcb;
  logic [XLEN-1:0] w_alu;
  logic [4:0]      w_shamt;
  logic            w_lt;
  logic            w_ltu;
  logic            w_eq;
  logic            w_cond;

  // ID/EX register; a flush or reset leaves a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_jalr       <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= 4'd0;
      r_funct3     <= 3'd0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_pc         <= RESET_PC;
      r_pc4        <= '0;
      r_imm        <= '0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
    end else if (FlushE) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_jalr       <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= 4'd0;
      r_funct3     <= 3'd0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_pc         <= RESET_PC;
      r_pc4        <= '0;
      r_imm        <= '0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
    end else begin
      r_reg_write  <= RegWriteD;
      r_mem_write  <= MemWriteD;
      r_result_src <= ResultSrcD;
      r_branch     <= BranchD;
      r_jump       <= JumpD;
      r_jalr       <= JalrD;
      r_alu_src    <= ALUSrcD;
      r_alu_ctrl   <= ALUControlD;
      r_funct3     <= funct3D;
      r_rd1        <= RD1D;
      r_rd2        <= RD2D;
      r_pc         <= PCD;
      r_pc4        <= PCplus4D;
      r_imm        <= ImmExtD;
      r_rs1        <= rs1D;
      r_rs2        <= rs2D;
      r_rd         <= rdD;
    end
  end

  // operand forwarding; code 11 falls back to the register value
  always_comb begin
    w_srca  = r_rd1;
    w_wdata = r_rd2;
    case (ForwardAE)
      2'b01:   w_srca = ResultW;
      2'b10:   w_srca = ALUResultM;
      default: w_srca = r_rd1;
    endcase
    case (ForwardBE)
      2'b01:   w_wdata = ResultW;
      2'b10:   w_wdata = ALUResultM;
      default: w_wdata = r_rd2;
    endcase
  end

  assign w_srcb  = r_alu_src ? r_imm : w_wdata;
  assign w_shamt = w_srcb[4:0];

  // ALU
  always_comb begin
    w_alu = '0;
    case (r_alu_ctrl)
      4'b0000: w_alu = w_srca + w_srcb;
      4'b0001: w_alu = w_srca - w_srcb;
      4'b0010: w_alu = w_srca & w_srcb;
      4'b0011: w_alu = w_srca | w_srcb;
      4'b0100: w_alu = w_srca ^ w_srcb;
      4'b0101: w_alu = {{(XLEN-1){1'b0}},
                        $signed(w_srca) < $signed(w_srcb)};
      4'b0110: w_alu = {{(XLEN-1){1'b0}}, w_srca < w_srcb};
      4'b0111: w_alu = w_srca << w_shamt;
      4'b1000: w_alu = w_srca >> w_shamt;
      4'b1001: w_alu = $unsigned($signed(w_srca) >>> w_shamt);
      4'b1010: w_alu = w_srcb;
      default: w_alu = '0;
    endcase
  end

  // branch compare works on the register operands, not the immediate
  assign w_eq  = (w_srca == w_wdata);
  assign w_lt  = ($signed(w_srca) < $signed(w_wdata));
  assign w_ltu = (w_srca < w_wdata);

  // branch condition select
  always_comb begin
    w_cond = 1'b0;
    case (r_funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = ~w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = ~w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = ~w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  assign RegWriteE  = r_reg_write;
  assign MemWriteE  = r_mem_write;
  assign ResultSrcE = r_result_src;
  assign rdE        = r_rd;
  assign rs1E       = r_rs1;
  assign rs2E       = r_rs2;
  assign PCplus4E   = r_pc4;
  assign ALUResultE = w_alu;
  assign WriteDataE = w_wdata;
  assign PCTargetE  = r_jalr ? {w_alu[XLEN-1:1], 1'b0}
                             : r_pc + r_imm;
  assign PCSrcE     = r_jump | (r_branch & w_cond);

endmodule
